fp_subtractor_seq: RTL
======================

FP_SUBTRACTOR_SEQ -- requirements
Module: fp_subtractor_seq

Interface
REQ-001 SHALL take sig_width and exp_width from floating_point_pkg (double precision: sig_width = 52, exp_width = 11); the block has no local parameters.
REQ-002 SHALL use floating_point_number_t from floating_point_pkg ({sign, exponent[exp_width-1:0], significand[sig_width-1:0]}) for all operand and result ports.
REQ-003 clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 in_valid  input  1  op1/op2 valid.
REQ-006 in_ready  output  1  block can accept operands.
REQ-007 op1  input  floating_point_number_t  minuend.
REQ-008 op2  input  floating_point_number_t  subtrahend.
REQ-009 out_valid  output  1  res and invalid_res valid.
REQ-010 out_ready  input  1  consumer accepts the result.
REQ-011 res  output  floating_point_number_t  op1 - op2.
REQ-012 invalid_res  output  1  exponent overflow or underflow occurred.

Function
REQ-013 SHALL compute res = op1 - op2 by inverting op2.sign and then adding with a hidden leading 1 on both operands; no rounding (truncate), no denormal/inf/NaN handling; the exponent is the raw unsigned biased field.
REQ-014 FSM states SHALL be IDLE, ALIGN, ADD, NORM and DONE; only one operation is in flight at a time.
REQ-015 in_ready SHALL be 1 only in IDLE with rst low; an operand transfer occurs on a clock edge where in_valid && in_ready, and op1/op2 are captured into internal registers at that edge.
REQ-016 On transfer, with d = |exp1 - exp2| and d' = min(d, sig_width+2): SHALL go to ALIGN if d' > 0, else to ADD.
REQ-017 ALIGN: SHALL shift the smaller-exponent significand right by 1 per cycle for d' cycles, discarding the shifted-out bits; the working exponent is the larger exponent; then go to ADD.
REQ-018 ADD (1 cycle), same effective signs: sum = sig1 + sig2 into a (sig_width+2)-bit register, sign = op1.sign.
REQ-019 ADD, differing effective signs: sum = larger - smaller significand, sign taken from the larger-magnitude operand; equal magnitudes give sum 0.
REQ-020 NORM on carry (bit sig_width+1): SHALL shift right 1 and set exp+1; if exp was 2^exp_width-1, set invalid; then go to DONE.
REQ-021 NORM with sum == 0: SHALL set res = 0 (sign 0, exponent 0, significand 0), invalid 0, and go to DONE.
REQ-022 NORM with bit sig_width = 0 and exp > 0: SHALL shift left 1 and set exp-1, one bit per cycle, re-checking each cycle; with bit sig_width = 1, go to DONE.
REQ-023 NORM with bit sig_width = 0 and exp == 0: SHALL set invalid (underflow) and go to DONE.
REQ-024 Whenever invalid is set, res SHALL be all zeros and invalid_res = 1.
REQ-025 Latency: out_valid SHALL rise d' + k + 2 cycles after the transfer edge, where k = number of left shifts.
REQ-026 DONE: out_valid = 1, and res/invalid_res SHALL stay stable until a clock edge with out_ready = 1; that edge returns the FSM to IDLE, with in_ready = 1 in the next cycle (no same-cycle accept).

Reset
REQ-027 While rst is high at an edge: state -> IDLE, out_valid = 0, res = 0, invalid_res = 0, internal registers cleared; in_ready = 0 during the rst-high cycle.
REQ-028 rst asserted mid-operation (any state) SHALL abort the operation with no output produced; in_ready = 1 in the first cycle after rst deasserts.

Verification
REQ-029 op1 = 0x4008000000000000 (3.0), op2 = 0x3FF0000000000000 (1.0) -> res = 0x4000000000000000, invalid 0, out_valid 3 cycles after transfer.
REQ-030 op1 = op2 = 0x3FF0000000000000 -> res = 0x0000000000000000, invalid 0, latency 2.
REQ-031 op1 = 0x3FF8000000000000 (1.5), op2 = 0x3FF0000000000000 -> res = 0x3FE0000000000000, latency 3.
REQ-032 op1 = 0x3FF0000000000000, op2 = 0xBFF0000000000000 -> res = 0x4000000000000000, latency 2.
REQ-033 op1 = 0x7FF0000000000000, op2 = 0xFFF0000000000000 -> invalid 1, res = 0 (overflow).
REQ-034 op1 = 0x0008000000000000, op2 = 0x0000000000000000 -> invalid 1, res = 0 (underflow).
REQ-035 Hold out_ready = 0 for 5 cycles -> res stable and in_ready = 0 throughout.
REQ-036 Assert rst in the NORM state -> out_valid never rises for that operation.

Source files
------------

// File: rtl/fp_subtractor_seq.sv
// Multi-cycle double-precision subtractor: res = op1 - op2 with truncation and
// a hidden leading one, one operation in flight, valid/ready on both sides.
package floating_point_pkg;
  localparam int sig_width = 52;
  localparam int exp_width = 11;

  typedef struct packed {
    logic                 sign;
    logic [exp_width-1:0] exponent;
    logic [sig_width-1:0] significand;
  } floating_point_number_t;
endpackage

module fp_subtractor_seq
  import floating_point_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  floating_point_number_t op1,
  input  floating_point_number_t op2,
  output logic                   out_valid,
  input  logic                   out_ready,
  output floating_point_number_t res,
  output logic                   invalid_res
);

  typedef enum logic [2:0] {IDLE, ALIGN, ADD, NORM, DONE} state_t;

  state_t               state;
  logic [sig_width+1:0] sig_big;
  logic [sig_width+1:0] sig_small;
  logic [sig_width+1:0] sum;
  logic [exp_width-1:0] exp_w;
  logic [exp_width-1:0] shift_cnt;
  logic                 sign_big;
  logic                 sign_small;
  logic                 res_sign;

  logic                 op1_is_big;
  logic [exp_width-1:0] exp_diff;
  logic [exp_width-1:0] shift_dist;

  // Beyond sig_width+2 right shifts the smaller significand is already zero.
  function automatic logic [exp_width-1:0] clamp_shift(input logic [exp_width-1:0] d);
    if (d > exp_width'(sig_width + 2))
      return exp_width'(sig_width + 2);
    else
      return d;
  endfunction

  assign in_ready = (state == IDLE) && !rst;

  always_comb begin
    op1_is_big = (op1.exponent >= op2.exponent);
    exp_diff   = op1_is_big ? (op1.exponent - op2.exponent)
                            : (op2.exponent - op1.exponent);
    shift_dist = clamp_shift(exp_diff);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      out_valid   <= 1'b0;
      res         <= '0;
      invalid_res <= 1'b0;
      sig_big     <= '0;
      sig_small   <= '0;
      sum         <= '0;
      exp_w       <= '0;
      shift_cnt   <= '0;
      sign_big    <= 1'b0;
      sign_small  <= 1'b0;
      res_sign    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            // op2's sign is inverted here so the rest of the datapath only adds.
            if (op1_is_big) begin
              sig_big    <= {2'b01, op1.significand};
              sig_small  <= {2'b01, op2.significand};
              sign_big   <= op1.sign;
              sign_small <= ~op2.sign;
              exp_w      <= op1.exponent;
            end else begin
              sig_big    <= {2'b01, op2.significand};
              sig_small  <= {2'b01, op1.significand};
              sign_big   <= ~op2.sign;
              sign_small <= op1.sign;
              exp_w      <= op2.exponent;
            end
            shift_cnt <= shift_dist;
            state     <= (shift_dist != '0) ? ALIGN : ADD;
          end
        end

        ALIGN: begin
          sig_small <= sig_small >> 1;
          shift_cnt <= shift_cnt - exp_width'(1);
          if (shift_cnt == exp_width'(1))
            state <= ADD;
        end

        ADD: begin
          if (sign_big == sign_small) begin
            sum      <= sig_big + sig_small;
            res_sign <= sign_big;
          end else if (sig_big > sig_small) begin
            sum      <= sig_big - sig_small;
            res_sign <= sign_big;
          end else if (sig_small > sig_big) begin
            sum      <= sig_small - sig_big;
            res_sign <= sign_small;
          end else begin
            sum      <= '0;
            res_sign <= 1'b0;
          end
          state <= NORM;
        end

        NORM: begin
          if (sum[sig_width+1]) begin
            if (exp_w == '1) begin
              res         <= '0;
              invalid_res <= 1'b1;
            end else begin
              res         <= {res_sign, exp_w + exp_width'(1), sum[sig_width:1]};
              invalid_res <= 1'b0;
            end
            out_valid <= 1'b1;
            state     <= DONE;
          end else if (sum == '0) begin
            res         <= '0;
            invalid_res <= 1'b0;
            out_valid   <= 1'b1;
            state       <= DONE;
          end else if (sum[sig_width]) begin
            res         <= {res_sign, exp_w, sum[sig_width-1:0]};
            invalid_res <= 1'b0;
            out_valid   <= 1'b1;
            state       <= DONE;
          end else if (exp_w == '0) begin
            res         <= '0;
            invalid_res <= 1'b1;
            out_valid   <= 1'b1;
            state       <= DONE;
          end else begin
            // One normalisation step per cycle; re-examined next cycle.
            sum   <= sum << 1;
            exp_w <= exp_w - exp_width'(1);
          end
        end

        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule
